// File: rtl/param_fifo.sv
// param_fifo: parameterised synchronous FIFO with first-word fall-through or registered-read output
module param_fifo #(
   parameter int DEPTH    = 16,
   parameter int WIDTH    = 8,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       data_in,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       data_out,
   output logic                   rd_valid,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic                   underflow,
   input  logic                   clr_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             rd_valid_q, rd_valid_d;
   logic             overflow_q, overflow_d, underflow_q, underflow_d;
   logic             wr_acc, rd_acc;
   assign full         = level_q == LW'(DEPTH);
   assign empty        = level_q == '0;
   assign almost_full  = level_q >= LW'(AF_LEVEL);
   assign almost_empty = level_q <= LW'(AE_LEVEL);
   assign level        = level_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;
   assign data_out     = FWFT != 0 ? (empty ? '0 : mem_q[rd_ptr_q]) : dout_q;
   assign rd_valid     = FWFT != 0 ? !empty : rd_valid_q;
   // acceptance decode and next-state; a read at full frees the slot the write uses
   always_comb begin
      rd_acc      = rd_en && !empty;
      wr_acc      = wr_en && (!full || rd_acc);
      wr_ptr_d    = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d    = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d     = (wr_acc && !rd_acc) ? level_q + LW'(1) : (rd_acc && !wr_acc) ? level_q - LW'(1) : level_q;
      overflow_d  = (wr_en && !wr_acc) || (overflow_q && !clr_err);
      underflow_d = (rd_en && !rd_acc) || (underflow_q && !clr_err);
      rd_valid_d  = rd_acc;
      dout_d      = rd_acc ? mem_q[rd_ptr_q] : dout_q;
   end
   // control state; reset overrides every request in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         dout_q      <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         dout_q      <= dout_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end
   // storage write port; contents are deliberately left unreset
   always_ff @(posedge clk) begin
      if (wr_acc && !rst) mem_q[wr_ptr_q] <= data_in;
   end
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed plus random checks of both read modes against a queue model
module tb_param_fifo;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
   logic [7:0] data_in = '0;
   logic [7:0] dout1, dout0;
   logic rv1, rv0, full1, full0, empty1, empty0, af1, af0, ae1, ae0, ovf1, ovf0, unf1, unf0;
   logic [2:0] lvl1, lvl0;
   int checks = 0;
   int errors = 0;
   logic [7:0] q[$];
   bit m_ovf, m_unf, m_rv;
   logic [7:0] m_dout;

   always #5 clk = ~clk;

   param_fifo #(.DEPTH(DEPTH), .WIDTH(8), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(dout1), .rd_valid(rv1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .level(lvl1),
      .overflow(ovf1), .underflow(unf1), .clr_err(clr_err));

   param_fifo #(.DEPTH(DEPTH), .WIDTH(8), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u0 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(dout0), .rd_valid(rv0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .level(lvl0),
      .overflow(ovf0), .underflow(unf0), .clr_err(clr_err));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c, input bit rs);
      bit rok, wok;
      int n;
      @(negedge clk);
      wr_en = w; data_in = d; rd_en = r; clr_err = c; rst = rs;
      @(posedge clk);
      if (rs) begin
         q.delete();
         m_ovf = 0; m_unf = 0; m_rv = 0; m_dout = '0;
      end else begin
         rok = r && q.size() > 0;
         wok = w && (q.size() < DEPTH || rok);
         m_rv = rok;
         if (rok) m_dout = q.pop_front();
         if (wok) q.push_back(d);
         m_ovf = (w && !wok) || (m_ovf && !c);
         m_unf = (r && !rok) || (m_unf && !c);
      end
      #1;
      n = q.size();
      chk("level1", lvl1, n);
      chk("level0", lvl0, n);
      chk("full1", full1, n == DEPTH);
      chk("full0", full0, n == DEPTH);
      chk("empty1", empty1, n == 0);
      chk("empty0", empty0, n == 0);
      chk("afull1", af1, n >= 3);
      chk("afull0", af0, n >= 3);
      chk("aempty1", ae1, n <= 1);
      chk("aempty0", ae0, n <= 1);
      chk("overflow1", ovf1, m_ovf);
      chk("overflow0", ovf0, m_ovf);
      chk("underflow1", unf1, m_unf);
      chk("underflow0", unf0, m_unf);
      chk("rd_valid1", rv1, n > 0);
      if (n > 0) chk("data_out1", dout1, q[0]);
      chk("rd_valid0", rv0, m_rv);
      chk("data_out0", dout0, m_dout);
   endtask

   initial begin
      step(0, 8'h00, 0, 0, 1);
      step(0, 8'h00, 0, 0, 1);
      // fill and drain
      step(1, 8'h11, 0, 0, 0);
      step(1, 8'h22, 0, 0, 0);
      step(1, 8'h33, 0, 0, 0);
      step(1, 8'h44, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
      // overflow at full, then clear
      for (int i = 1; i <= 4; i++) step(1, 8'(8'hA0 + i), 0, 0, 0);
      step(1, 8'h55, 0, 0, 0);
      step(0, 8'h00, 0, 1, 0);
      step(0, 8'h00, 0, 0, 0);
      // simultaneous access at full
      step(1, 8'h66, 1, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
      // simultaneous access at empty
      step(1, 8'h77, 1, 0, 0);
      step(0, 8'h00, 0, 0, 0);
      step(0, 8'h00, 1, 1, 0);
      // registered-read latency
      step(1, 8'hA5, 0, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      step(0, 8'h00, 0, 0, 0);
      step(0, 8'h00, 0, 0, 0);
      // streaming across the pointer wrap, then reset with words stored
      for (int i = 0; i < 10; i++) step(1, 8'(i), i > 0, 0, 0);
      step(1, 8'hEE, 0, 0, 0);
      step(1, 8'hEF, 1, 0, 1);
      step(0, 8'h00, 1, 0, 0);
      step(0, 8'h00, 0, 1, 0);
      // random traffic
      for (int i = 0; i < 600; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
              $urandom_range(0, 15) == 0, $urandom_range(0, 79) == 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
